// File: rtl/line_buf_rd_ctrl_pkg.sv
// vid_line_pkg: shared FSM encoding and default widths for the line-buffer read controller
package vid_line_pkg;
  localparam int DEF_ADDR_WIDTH = 11;
  localparam int DEF_DATA_WIDTH = 24;
  localparam int DEF_LEN_WIDTH = 12;
  localparam int MAX_LINE = 2048;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } line_state_e;
endpackage

// File: rtl/line_buf_rd_ctrl_if.sv
// line_buf_rd_ctrl_if: valid/ready pixel stream with end-of-line marker
interface line_buf_rd_ctrl_if #(
  parameter int DATA_WIDTH = 24
);
  logic [DATA_WIDTH-1:0] m_data;
  logic m_valid;
  logic m_ready;
  logic m_last;
  modport master(output m_data, m_valid, m_last, input m_ready);
  modport slave(input m_data, m_valid, m_last, output m_ready);
endinterface

// File: rtl/line_buf_rd_ctrl_skid_fifo.sv
// line_rd_skid_fifo: small register FIFO catching RAM beats still in flight when the stream stalls
module line_rd_skid_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 2,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  logic pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0] count_o
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) mem_q[wp_q] <= data_i;
      wp_q <= push_i ? nxt(wp_q) : wp_q;
      rp_q <= pop_i ? nxt(rp_q) : rp_q;
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  assign data_o = mem_q[rp_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/line_buf_rd_ctrl.sv
// line_buf_rd_ctrl: walks line RAM addresses and streams pixels out with end-of-line marking
module line_buf_rd_ctrl
  import vid_line_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH = DEF_LEN_WIDTH,
  parameter int RAM_LATENCY = 1
) (
  input  logic rd_clk,
  input  logic rd_rst,
  input  logic line_req_i,
  input  logic [ADDR_WIDTH-1:0] line_base_i,
  input  logic [LEN_WIDTH-1:0] line_len_i,
  output logic busy_o,
  output logic line_done_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  line_buf_rd_ctrl_if.master m
);
  localparam int DEPTH = RAM_LATENCY + 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int LMAX = 2 ** ADDR_WIDTH;
  line_state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0] rem_q, len_clamp;
  logic [RAM_LATENCY-1:0] iv_q, il_q;
  logic done_q, accept, issue, final_issue, space, pop;
  logic [CW-1:0] fifo_count;
  logic [DATA_WIDTH:0] fifo_out;
  int inflight;
  always_ff @(posedge rd_clk or posedge rd_rst)
    if (rd_rst) state_q <= IDLE;
    else state_q <= state_d;
  // the done cycle still counts as busy, so a request landing on it is dropped
  assign accept = state_q == IDLE && !done_q && line_req_i && line_len_i != '0;
  assign pop = m.m_valid && m.m_ready;
  always_comb
    state_d = accept ? READ
            : (state_q == READ && final_issue) ? DRAIN
            : (state_q == DRAIN && pop && m.m_last) ? IDLE
            : state_q;
  always_comb begin
    inflight = 0;
    for (int i = 0; i < RAM_LATENCY; i++) inflight += int'(iv_q[i]);
  end
  always_comb begin
    busy_o = state_q != IDLE || done_q;
    space = int'(fifo_count) + inflight - int'(pop) < DEPTH;
    issue = state_q == READ && space;
    final_issue = issue && rem_q == LEN_WIDTH'(1);
  end
  assign len_clamp = (line_len_i > LEN_WIDTH'(LMAX)) ? LEN_WIDTH'(LMAX) : line_len_i;
  always_ff @(posedge rd_clk or posedge rd_rst)
    if (rd_rst) begin
      addr_q <= '0;
      rem_q <= '0;
      iv_q <= '0;
      il_q <= '0;
      done_q <= 1'b0;
    end else begin
      addr_q <= accept ? line_base_i : (issue && !final_issue) ? addr_q + ADDR_WIDTH'(1) : addr_q;
      rem_q <= accept ? len_clamp : issue ? rem_q - LEN_WIDTH'(1) : rem_q;
      iv_q <= RAM_LATENCY'({iv_q, issue});
      il_q <= RAM_LATENCY'({il_q, final_issue});
      done_q <= pop && m.m_last;
    end
  line_rd_skid_fifo #(.WIDTH(DATA_WIDTH + 1), .DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk(rd_clk),
    .rst(rd_rst),
    .push_i(iv_q[RAM_LATENCY-1]),
    .pop_i(pop),
    .data_i({il_q[RAM_LATENCY-1], rd_data_i}),
    .data_o(fifo_out),
    .count_o(fifo_count)
  );
  assign m.m_valid = fifo_count != '0;
  assign m.m_data = fifo_out[DATA_WIDTH-1:0];
  assign m.m_last = m.m_valid && fifo_out[DATA_WIDTH];
  assign line_done_o = done_q;
  assign rd_addr_o = addr_q;
endmodule

// File: tb/tb_line_buf_rd_ctrl.sv
// tb_line_buf_rd_ctrl: directed and random lines checked against a per-line pixel model
module tb_line_buf_rd_ctrl;
  logic clk = 0, rst = 1, line_req = 0, busy, line_done;
  logic [10:0] line_base = '0, rd_addr;
  logic [11:0] line_len = '0;
  logic [23:0] rd_data = '0;
  logic [23:0] ram [2048];
  int n_cmp = 0, n_err = 0, done_cnt = 0, cyc = 0, first_cyc = 0, last_cyc = 0, rdy_mode = 0;
  logic [24:0] rx_q [$];
  logic prev_stall = 0;
  logic [24:0] prev_beat = '0;
  line_buf_rd_ctrl_if #(.DATA_WIDTH(24)) s ();
  line_buf_rd_ctrl dut (
    .rd_clk(clk), .rd_rst(rst), .line_req_i(line_req), .line_base_i(line_base),
    .line_len_i(line_len), .busy_o(busy), .line_done_o(line_done), .rd_addr_o(rd_addr),
    .rd_data_i(rd_data), .m(s)
  );
  always #5 clk = ~clk;
  initial for (int a = 0; a < 2048; a++) ram[a] = 24'(a) ^ 24'hA50000;
  always @(posedge clk) rd_data <= ram[rd_addr];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [23:0] exp_pix(input logic [10:0] b, input int i);
    logic [10:0] a;
    a = b + 11'(i);
    return 24'hA50000 ^ {13'd0, a};
  endfunction
  initial begin
    s.m_ready = 1;
    forever begin
      @(posedge clk);
      #1;
      s.m_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? ~s.m_ready : ($urandom_range(0, 3) != 0);
    end
  end
  always @(negedge clk) begin
    cyc++;
    if (rst) prev_stall = 0;
    else begin
      if (prev_stall) chk("stall hold", 32'({s.m_valid, s.m_last, s.m_data}), 32'({1'b1, prev_beat}));
      chk("fifo overflow", 32'(int'(dut.u_fifo.cnt_q) <= 2), 1);
      if (s.m_valid && s.m_ready) begin
        if (rx_q.size() == 0) first_cyc = cyc;
        last_cyc = cyc;
        rx_q.push_back({s.m_last, s.m_data});
      end
      if (line_done) done_cnt++;
      prev_stall = s.m_valid && !s.m_ready;
      prev_beat = {s.m_last, s.m_data};
    end
  end
  task automatic start_line(input logic [10:0] b, input logic [11:0] l);
    @(posedge clk);
    #1;
    line_req = 1; line_base = b; line_len = l;
    @(posedge clk);
    #1;
    line_req = 0;
  endtask
  task automatic check_line(input string tag, input logic [10:0] b, input logic [11:0] l, input int d0);
    int n, t;
    n = (l > 12'd2048) ? 2048 : int'(l);
    t = 0;
    while (done_cnt == d0 && t < 20000) begin @(negedge clk); t++; end
    repeat (4) @(negedge clk);
    chk({tag, " done"}, 32'(done_cnt - d0), 1);
    chk({tag, " beats"}, 32'(rx_q.size()), 32'(n));
    for (int i = 0; i < n && i < rx_q.size(); i++)
      chk($sformatf("%s px%0d", tag, i), 32'(rx_q[i]), 32'({i == n - 1, exp_pix(b, i)}));
  endtask
  task automatic run_line(input string tag, input logic [10:0] b, input logic [11:0] l);
    int d0;
    rx_q.delete();
    d0 = done_cnt;
    start_line(b, l);
    check_line(tag, b, l, d0);
  endtask
  initial begin
    int d0, t;
    logic [10:0] b;
    logic [11:0] l;
    @(negedge clk);
    chk("reset outs", 32'({busy, line_done, rd_addr, s.m_valid, s.m_last}), 0);
    chk("reset data", 32'(s.m_data), 0);
    @(posedge clk);
    #1 rst = 0;
    rx_q.delete();
    d0 = done_cnt;
    start_line(0, 4);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("t1 addr@t%0d", k), 32'(rd_addr), 32'(k < 5 ? k - 1 : 3));
      chk($sformatf("t1 valid@t%0d", k), 32'(s.m_valid), 32'(k >= 3 && k <= 6));
      if (k >= 3 && k <= 6)
        chk($sformatf("t1 beat@t%0d", k), 32'({s.m_last, s.m_data}), 32'({k == 6, 24'hA50000 + 24'(k - 3)}));
      chk($sformatf("t1 done@t%0d", k), 32'(line_done), 32'(k == 7));
      chk($sformatf("t1 busy@t%0d", k), 32'(busy), 32'(k <= 7));
    end
    check_line("t1", 0, 4, d0);
    run_line("t2 wrap", 2046, 4);
    rdy_mode = 1;
    run_line("t3 toggle", 100, 8);
    rdy_mode = 0;
    rx_q.delete();
    d0 = done_cnt;
    start_line(200, 6);
    start_line(500, 3);
    check_line("t4 busy req", 200, 6, d0);
    d0 = done_cnt;
    start_line(7, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t4 len0 busy", 32'(busy), 0);
    end
    chk("t4 len0 done", 32'(done_cnt - d0), 0);
    chk("t4 len0 beats", 32'(rx_q.size()), 6);
    start_line(300, 3);
    t = 0;
    while (!line_done && t < 100) begin @(negedge clk); t++; end
    chk("t4 done seen a", 32'(line_done), 1);
    line_req = 1; line_base = 40; line_len = 2;
    @(posedge clk);
    #1 line_req = 0;
    repeat (3) begin
      @(negedge clk);
      chk("t4 req on done", 32'(busy), 0);
    end
    start_line(300, 3);
    t = 0;
    while (!line_done && t < 100) begin @(negedge clk); t++; end
    chk("t4 done seen b", 32'(line_done), 1);
    line_req = 1; line_base = 40; line_len = 2;
    @(posedge clk);
    d0 = done_cnt;
    rx_q.delete();
    @(posedge clk);
    #1 line_req = 0;
    @(negedge clk);
    chk("t4 req after done", 32'(busy), 1);
    check_line("t4 after done", 40, 2, d0);
    rx_q.delete();
    d0 = done_cnt;
    start_line(10, 16);
    t = 0;
    while (rx_q.size() < 3 && t < 100) begin @(posedge clk); t++; end
    chk("t5 three beats", 32'(rx_q.size()), 3);
    #1 rst = 1;
    @(negedge clk);
    chk("t5 rst outs", 32'({busy, line_done, rd_addr, s.m_valid, s.m_last}), 0);
    chk("t5 rst data", 32'(s.m_data), 0);
    @(posedge clk);
    #1 rst = 0;
    repeat (6) @(negedge clk);
    chk("t5 no done", 32'(done_cnt - d0), 0);
    run_line("t5 after rst", 10, 2);
    run_line("t6 full", 0, 2048);
    chk("t6 full gapless", 32'(last_cyc - first_cyc), 2047);
    run_line("t6 clamp", 0, 4095);
    chk("t6 clamp gapless", 32'(last_cyc - first_cyc), 2047);
    rdy_mode = 2;
    for (int r = 0; r < 20; r++) begin
      b = 11'($urandom_range(0, 2047));
      l = 12'($urandom_range(1, r % 4 == 0 ? 300 : 40));
      run_line($sformatf("rand%0d", r), b, l);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
